// File: rtl/instr_decode_queue.sv
// Decoupling instruction queue between IF and ID: pre-classifies fetched words and issues an
// in-order prefix obeying MIPS pairing/delay-slot rules. Optional IF->ID bypass: DECODE_QUEUE_BYPASS_EN.
module instr_decode_queue #(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(IN_WIDTH+1)-1:0]  IF_Num,
  input  logic [IN_WIDTH*32-1:0]         IF_Instr,
  input  logic [IN_WIDTH*32-1:0]         IF_PC,
  output logic                           IF_Ready,
  input  logic                           Flush,
  input  logic                           ID_Ready,
  output logic [OUT_WIDTH-1:0]           ID_Valid,
  output logic [OUT_WIDTH*32-1:0]        ID_Instr,
  output logic [OUT_WIDTH*32-1:0]        ID_PC,
  output logic [OUT_WIDTH*3-1:0]         ID_Class
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_BRANCH  = 3'd1,
    CLS_JUMP    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_MULDIV  = 3'd5,
    CLS_PRIV    = 3'd6,
    CLS_INVALID = 3'd7
  } cls_e;

  function automatic cls_e classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    classify = CLS_INVALID;
    casez (op)
      6'b000000: begin
        casez (fn)
          6'b00100?:            classify = CLS_JUMP;
          6'b0100??, 6'b0110??: classify = CLS_MULDIV;
          6'b00110?:            classify = CLS_PRIV;
          default:              classify = CLS_ALU;
        endcase
      end
      6'b000001, 6'b0001??: classify = CLS_BRANCH;
      6'b00001?:            classify = CLS_JUMP;
      6'b001???:            classify = CLS_ALU;
      6'b010000:            classify = CLS_PRIV;
      6'b100???:            classify = CLS_LOAD;
      6'b101???:            classify = CLS_STORE;
      default:              classify = CLS_INVALID;
    endcase
  endfunction

  function automatic logic is_bj(input cls_e c);
    return (c == CLS_BRANCH) || (c == CLS_JUMP);
  endfunction

  function automatic logic is_pi(input cls_e c);
    return (c == CLS_PRIV) || (c == CLS_INVALID);
  endfunction

  logic [31:0]    mem_instr [DEPTH];
  logic [31:0]    mem_pc    [DEPTH];
  cls_e           mem_cls   [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  cls_e           lane_cls [IN_WIDTH];
  logic [31:0]    c_instr  [OUT_WIDTH];
  logic [31:0]    c_pc     [OUT_WIDTH];
  cls_e           c_cls    [OUT_WIDTH];
  logic [OUT_WIDTH-1:0] valid;
  logic           bypass;
  int             if_num_i;
  int             cnt_i;
  int             deq_i;
  int             enq_i;
  int             skip_i;

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      lane_cls[i] = classify(IF_Instr[32*i +: 32]);
    end
  end

  // IF side: a beat of IF_Num lanes is taken whenever IF_Ready=1 and Flush=0 (no back-pressure
  // per lane). ID side: all asserted ID_Valid slots retire together in a cycle with ID_Ready=1.
  assign IF_Ready = !rst && ((DEPTH - int'(count)) >= IN_WIDTH);

  always_comb begin
    if_num_i = (int'(IF_Num) > IN_WIDTH) ? IN_WIDTH : int'(IF_Num);
    cnt_i    = int'(count);
    bypass   = 1'b0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      c_instr[k] = mem_instr[head + PW'(k)];
      c_pc[k]    = mem_pc[head + PW'(k)];
      c_cls[k]   = mem_cls[head + PW'(k)];
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    if (count == '0 && !Flush && if_num_i > 0) begin
      bypass = 1'b1;
      cnt_i  = if_num_i;
      for (int k = 0; k < OUT_WIDTH && k < IN_WIDTH; k++) begin
        c_instr[k] = IF_Instr[32*k +: 32];
        c_pc[k]    = IF_PC[32*k +: 32];
        c_cls[k]   = lane_cls[k];
      end
    end
`endif
    valid    = '0;
    // A branch/jump waits at slot 0 until its delay slot can issue alongside it.
    valid[0] = (cnt_i >= 1) && !(is_bj(c_cls[0]) && OUT_WIDTH >= 2 && cnt_i < 2);
    for (int k = 1; k < OUT_WIDTH; k++) begin
      if (k == 1) begin
        valid[k] = valid[k-1] && (cnt_i >= 2) &&
                   (is_bj(c_cls[0]) || (!is_pi(c_cls[0]) && !is_bj(c_cls[k]) && !is_pi(c_cls[k])));
      end else begin
        valid[k] = valid[k-1] && (cnt_i > k) && !is_bj(c_cls[0]) && !is_pi(c_cls[0]) &&
                   !is_pi(c_cls[k-1]) && !is_bj(c_cls[k]) && !is_pi(c_cls[k]);
      end
    end
    if (rst || Flush) valid = '0;
    deq_i = 0;
    if (ID_Ready) begin
      for (int k = 0; k < OUT_WIDTH; k++) deq_i += int'(valid[k]);
    end
    enq_i  = (IF_Ready && !Flush) ? if_num_i : 0;
    // Bypassed lanes consumed by ID are skipped; the rest land at tail as usual.
    skip_i = bypass ? deq_i : 0;
  end

  always_comb begin
    ID_Valid = valid;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      ID_Instr[32*k +: 32] = c_instr[k];
      ID_PC[32*k +: 32]    = c_pc[k];
      ID_Class[3*k +: 3]   = c_cls[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (Flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_i);
      tail  <= tail + PW'(enq_i);
      count <= CW'(int'(count) + enq_i - deq_i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (i >= skip_i && i < enq_i) begin
        mem_instr[tail + PW'(i)] <= IF_Instr[32*i +: 32];
        mem_pc[tail + PW'(i)]    <= IF_PC[32*i +: 32];
        mem_cls[tail + PW'(i)]   <= lane_cls[i];
      end
    end
  end

endmodule
